// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// The FSM state list and the magnitude helper live here so the top and the bench agree on them.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_e;

    // |v| as an unsigned value; 0x80000000 maps to itself, which is the exact magnitude
    function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH-1:0] res;
        if (v[DIV_WIDTH-1]) begin
            res = {DIV_WIDTH{1'b0}} - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the control unit and the divider.
interface seq_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ready;
    logic        div_zero;
    logic        busy;

    modport master (
        output start, a, b,
        input  hi, lo, ready, div_zero, busy
    );

    modport slave (
        input  start, a, b,
        output hi, lo, ready, div_zero, busy
    );
endinterface

// File: rtl/div_step.sv
// One unsigned restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH:0] rem_in,
    input  logic [DIV_WIDTH:0] divisor,
    input  logic               bit_in,
    output logic [DIV_WIDTH:0] rem_out,
    output logic               q_bit
);

    logic [DIV_WIDTH+1:0] shifted_s;

    assign shifted_s = {rem_in, bit_in};

    // Keep the difference only when the trial subtraction does not go negative
    always_comb begin
        rem_out = shifted_s[DIV_WIDTH:0];
        q_bit   = 1'b0;
        if (shifted_s >= {1'b0, divisor}) begin
            rem_out = shifted_s[DIV_WIDTH:0] - divisor;
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s[DIV_WIDTH:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// 32-bit signed sequential divider (quotient to lo, remainder to hi), 35 cycles per operation.
// Define SEQ_DIV_ZERO_DETECT_EN to short-circuit zero divisors with the div_zero flag.
module seq_divider
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);

    div_state_e             state_r;
    div_state_e             state_s;
    logic [DIV_WIDTH-1:0]   a_r;
    logic [DIV_WIDTH-1:0]   b_r;
    logic [DIV_WIDTH-1:0]   dq_r;
    logic [DIV_WIDTH:0]     dvs_r;
    logic [DIV_WIDTH:0]     rem_r;
    logic [DIV_CNT_W-1:0]   cnt_r;
    logic                   q_neg_r;
    logic                   r_neg_r;
    logic                   b_zero_r;
    logic [DIV_WIDTH-1:0]   hi_r;
    logic [DIV_WIDTH-1:0]   lo_r;
    logic                   ready_r;
    logic                   busy_r;
    logic [DIV_WIDTH:0]     step_rem_s;
    logic                   step_q_s;

    div_step u_step (
        .rem_in  (rem_r),
        .divisor (dvs_r),
        .bit_in  (dq_r[DIV_WIDTH-1]),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
`ifdef SEQ_DIV_ZERO_DETECT_EN
                if (b_r == 32'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
`else
                state_s = RUN;
`endif
            end
            RUN: begin
                if (cnt_r == DIV_CNT_W'(DIV_ITERS - 1)) begin
                    state_s = FIXUP;
                end else begin
                    state_s = RUN;
                end
            end
            FIXUP:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result load
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            dq_r     <= 32'd0;
            dvs_r    <= 33'd0;
            rem_r    <= 33'd0;
            cnt_r    <= 5'd0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            b_zero_r <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                    end
                end
                CHECK: begin
                    dq_r     <= mag(a_r);
                    dvs_r    <= {1'b0, mag(b_r)};
                    q_neg_r  <= a_r[DIV_WIDTH-1] ^ b_r[DIV_WIDTH-1];
                    r_neg_r  <= a_r[DIV_WIDTH-1];
                    b_zero_r <= (b_r == 32'd0);
                    rem_r    <= 33'd0;
                    cnt_r    <= 5'd0;
                end
                RUN: begin
                    // dq_r shifts dividend bits out at the top and quotient bits in at the bottom
                    rem_r <= step_rem_s;
                    dq_r  <= {dq_r[DIV_WIDTH-2:0], step_q_s};
                    cnt_r <= cnt_r + 5'd1;
                end
                FIXUP: begin
                    if (b_zero_r) begin
                        lo_r <= 32'hFFFF_FFFF;
                        hi_r <= a_r;
                    end else begin
                        lo_r <= q_neg_r ? (32'd0 - dq_r) : dq_r;
                        hi_r <= r_neg_r ? (32'd0 - rem_r[DIV_WIDTH-1:0]) : rem_r[DIV_WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs, registered from the next state so they line up with DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ready_r <= (state_s == DONE);
            busy_r  <= (state_s != IDLE);
        end
    end

`ifdef SEQ_DIV_ZERO_DETECT_EN
    logic div_zero_r;

    // Zero-divisor flag: cleared on a new request, set when CHECK sees b == 0
    always_ff @(posedge clk) begin
        if (reset) begin
            div_zero_r <= 1'b0;
        end else if (state_r == IDLE && bus.start) begin
            div_zero_r <= 1'b0;
        end else if (state_r == CHECK && b_r == 32'd0) begin
            div_zero_r <= 1'b1;
        end
    end

    assign bus.div_zero = div_zero_r;
`else
    assign bus.div_zero = 1'b0;
`endif

    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;

endmodule
